alu_decode: RTL and testbench

- Decode stage that feeds the ALU: the encoder-side producer of the one-hot ALU opcode and operand selects the ALU consumes.
- Accepts a fetched instruction and PC over a valid/ready handshake.
- Decodes RV32I integer, load/store, branch and jump forms into the one-hot opcode, operand selects, immediate and register fields.
- Holds the result in one ID/EX pipeline register with stall and flush.

---
 rtl/alu_decode_pkg.sv | 80 ++++++++
 rtl/alu_decode_imm_gen.sv | 31 +++
 rtl/alu_decode.sv | 218 +++++++++++++++++++++
 tb/tb_alu_decode.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_decode_pkg.sv
// Shared decode definitions: ALU op bit indices, RV32I major opcodes, operand-select
// and immediate-format enums, plus the f3-to-ALU-op helpers used by alu_decode.
package alu_decode_pkg;

    localparam int XLEN_C         = 32;
    localparam int ALU_OP_WIDTH_C = 10;

    typedef enum logic [3:0] {
        ALU_OP_ADD  = 4'd0,
        ALU_OP_SUB  = 4'd1,
        ALU_OP_SLL  = 4'd2,
        ALU_OP_SLT  = 4'd3,
        ALU_OP_SLTU = 4'd4,
        ALU_OP_XOR  = 4'd5,
        ALU_OP_SRL  = 4'd6,
        ALU_OP_SRA  = 4'd7,
        ALU_OP_OR   = 4'd8,
        ALU_OP_AND  = 4'd9
    } alu_op_idx_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_sel_e;

    typedef enum logic {
        SRC2_RS2 = 1'b0,
        SRC2_IMM = 1'b1
    } src2_sel_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    function automatic logic [ALU_OP_WIDTH_C-1:0] alu_onehot(input alu_op_idx_e idx);
        return {{(ALU_OP_WIDTH_C-1){1'b0}}, 1'b1} << idx;
    endfunction

    // alt is instr[30]; SUB only exists for register-register OP
    function automatic alu_op_idx_e alu_op_from_f3(input logic [2:0] f3, input logic alt,
                                                   input logic allow_sub);
        case (f3)
            3'b000:  return (alt & allow_sub) ? ALU_OP_SUB : ALU_OP_ADD;
            3'b001:  return ALU_OP_SLL;
            3'b010:  return ALU_OP_SLT;
            3'b011:  return ALU_OP_SLTU;
            3'b100:  return ALU_OP_XOR;
            3'b101:  return alt ? ALU_OP_SRA : ALU_OP_SRL;
            3'b110:  return ALU_OP_OR;
            3'b111:  return ALU_OP_AND;
            default: return ALU_OP_ADD;
        endcase
    endfunction

    function automatic alu_op_idx_e branch_op_from_f3(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001: return ALU_OP_SUB;
            3'b100, 3'b101: return ALU_OP_SLT;
            3'b110, 3'b111: return ALU_OP_SLTU;
            default:        return ALU_OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/alu_decode_imm_gen.sv
// Immediate generator: picks the RV32I immediate format and sign-extends from instr[31].
module alu_decode_imm_gen
    import alu_decode_pkg::*;
#(
    parameter int XLEN = XLEN_C
) (
    input  logic [31:0]     instr,
    input  imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm_32_s;

    // Format select; B and J drop bit 0, U fills the low 12 bits with zero
    always_comb begin
        imm_32_s = 32'd0;
        case (fmt)
            IMM_I:   imm_32_s = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm_32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm_32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                 instr[11:8], 1'b0};
            IMM_U:   imm_32_s = {instr[31:12], 12'd0};
            IMM_J:   imm_32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                 instr[30:21], 1'b0};
            default: imm_32_s = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm_32_s));

endmodule

// File: rtl/alu_decode.sv
// RV32I decode stage with a single ID/EX register (valid/ready, stall, flush).
// Define DECODE_ILLEGAL_CHECK_EN to enable full opcode/f3/f7 legality checking.
module alu_decode
    import alu_decode_pkg::*;
#(
    parameter int XLEN         = XLEN_C,
    parameter int ALU_OP_WIDTH = ALU_OP_WIDTH_C
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             in_instr,
    input  logic [XLEN-1:0]         in_pc,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ALU_OP_WIDTH-1:0] out_alu_opcode,
    output logic [1:0]              out_src1_sel,
    output logic                    out_src2_sel,
    output logic [XLEN-1:0]         out_imm,
    output logic [XLEN-1:0]         out_pc,
    output logic [4:0]              out_rs1,
    output logic [4:0]              out_rs2,
    output logic [4:0]              out_rd,
    output logic                    out_rd_wr,
    output logic                    out_illegal
);

    logic [6:0]  opc_s;
    logic [2:0]  f3_s;
    logic [4:0]  rd_s;
    logic        accept_s;

    alu_op_idx_e op_idx_s;
    src1_sel_e   src1_s;
    src2_sel_e   src2_s;
    imm_fmt_e    fmt_s;
    logic        wr_s;
    logic        illegal_s;
    logic [ALU_OP_WIDTH-1:0] opcode_s;
    logic        rd_wr_s;
    logic [XLEN-1:0] imm_s;

    logic                    valid_r;
    logic [ALU_OP_WIDTH-1:0] opcode_r;
    src1_sel_e               src1_sel_r;
    src2_sel_e               src2_sel_r;
    logic [XLEN-1:0]         imm_r;
    logic [XLEN-1:0]         pc_r;
    logic [4:0]              rs1_r;
    logic [4:0]              rs2_r;
    logic [4:0]              rd_r;
    logic                    rd_wr_r;
    logic                    illegal_r;

    assign opc_s    = in_instr[6:0];
    assign f3_s     = in_instr[14:12];
    assign rd_s     = in_instr[11:7];
    assign in_ready = ~valid_r | out_ready;
    assign accept_s = in_valid & in_ready;

    // Primary decode: ALU op, operand selects, immediate format, rd write intent
    always_comb begin
        op_idx_s = ALU_OP_ADD;
        src1_s   = SRC1_RS1;
        src2_s   = SRC2_RS2;
        fmt_s    = IMM_NONE;
        wr_s     = 1'b0;
        case (opc_s)
            OPC_OP: begin
                op_idx_s = alu_op_from_f3(f3_s, in_instr[30], 1'b1);
                wr_s     = 1'b1;
            end
            OPC_OP_IMM: begin
                op_idx_s = alu_op_from_f3(f3_s, in_instr[30], 1'b0);
                src2_s   = SRC2_IMM;
                fmt_s    = IMM_I;
                wr_s     = 1'b1;
            end
            OPC_LOAD, OPC_JALR: begin
                src2_s = SRC2_IMM;
                fmt_s  = IMM_I;
                wr_s   = 1'b1;
            end
            OPC_STORE: begin
                src2_s = SRC2_IMM;
                fmt_s  = IMM_S;
            end
            OPC_JAL: begin
                src1_s = SRC1_PC;
                src2_s = SRC2_IMM;
                fmt_s  = IMM_J;
                wr_s   = 1'b1;
            end
            OPC_AUIPC: begin
                src1_s = SRC1_PC;
                src2_s = SRC2_IMM;
                fmt_s  = IMM_U;
                wr_s   = 1'b1;
            end
            OPC_LUI: begin
                src1_s = SRC1_ZERO;
                src2_s = SRC2_IMM;
                fmt_s  = IMM_U;
                wr_s   = 1'b1;
            end
            OPC_BRANCH: begin
                op_idx_s = branch_op_from_f3(f3_s);
                fmt_s    = IMM_B;
            end
            default: fmt_s = IMM_NONE;
        endcase
    end

    // Legality check; without the feature every encoding is reported legal
    always_comb begin
`ifdef DECODE_ILLEGAL_CHECK_EN
        illegal_s = 1'b0;
        case (opc_s)
            OPC_OP: begin
                if (in_instr[31:25] == 7'h00) begin
                    illegal_s = 1'b0;
                end else if (in_instr[31:25] == 7'h20) begin
                    illegal_s = (f3_s != 3'b000) && (f3_s != 3'b101);
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                if (f3_s == 3'b001) begin
                    illegal_s = (in_instr[31:25] != 7'h00);
                end else if (f3_s == 3'b101) begin
                    illegal_s = (in_instr[31:25] != 7'h00) && (in_instr[31:25] != 7'h20);
                end else begin
                    illegal_s = 1'b0;
                end
            end
            OPC_LOAD:   illegal_s = (f3_s == 3'b011) || (f3_s == 3'b110) || (f3_s == 3'b111);
            OPC_STORE:  illegal_s = (f3_s > 3'b010);
            OPC_BRANCH: illegal_s = (f3_s == 3'b010) || (f3_s == 3'b011);
            OPC_JALR:   illegal_s = (f3_s != 3'b000);
            OPC_JAL, OPC_LUI, OPC_AUIPC: illegal_s = 1'b0;
            default:    illegal_s = 1'b1;
        endcase
`else
        illegal_s = 1'b0;
`endif
    end

    // Illegal encodings carry no ALU op and never write rd; rd==0 never writes
    always_comb begin
        if (illegal_s) begin
            opcode_s = {ALU_OP_WIDTH{1'b0}};
            rd_wr_s  = 1'b0;
        end else begin
            opcode_s = alu_onehot(op_idx_s);
            rd_wr_s  = wr_s & (rd_s != 5'd0);
        end
    end

    alu_decode_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr (in_instr),
        .fmt   (fmt_s),
        .imm   (imm_s)
    );

    // Entry validity: flush wins over accept and over a held entry
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            valid_r <= 1'b0;
        end else if (flush) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= accept_s | (valid_r & ~out_ready);
        end
    end

    // Payload loads only on an unflushed accept and otherwise holds
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            opcode_r   <= {ALU_OP_WIDTH{1'b0}};
            src1_sel_r <= SRC1_RS1;
            src2_sel_r <= SRC2_RS2;
            imm_r      <= {XLEN{1'b0}};
            pc_r       <= {XLEN{1'b0}};
            rs1_r      <= 5'd0;
            rs2_r      <= 5'd0;
            rd_r       <= 5'd0;
            rd_wr_r    <= 1'b0;
            illegal_r  <= 1'b0;
        end else if (accept_s && !flush) begin
            opcode_r   <= opcode_s;
            src1_sel_r <= src1_s;
            src2_sel_r <= src2_s;
            imm_r      <= imm_s;
            pc_r       <= in_pc;
            rs1_r      <= in_instr[19:15];
            rs2_r      <= in_instr[24:20];
            rd_r       <= rd_s;
            rd_wr_r    <= rd_wr_s;
            illegal_r  <= illegal_s;
        end
    end

    assign out_valid      = valid_r;
    assign out_alu_opcode = opcode_r;
    assign out_src1_sel   = src1_sel_r;
    assign out_src2_sel   = src2_sel_r;
    assign out_imm        = imm_r;
    assign out_pc         = pc_r;
    assign out_rs1        = rs1_r;
    assign out_rs2        = rs2_r;
    assign out_rd         = rd_r;
    assign out_rd_wr      = rd_wr_r;
    assign out_illegal    = illegal_r;

endmodule

// File: tb/tb_alu_decode.sv
// Scoreboard bench for alu_decode: directed RV32I vectors with hand-computed expectations.
module tb_alu_decode;

    localparam logic [9:0] OP_NONE = 10'h000;
    localparam logic [9:0] OP_ADD  = 10'h001;
    localparam logic [9:0] OP_SUB  = 10'h002;
    localparam logic [9:0] OP_SLL  = 10'h004;
    localparam logic [9:0] OP_SLT  = 10'h008;
    localparam logic [9:0] OP_SLTU = 10'h010;
    localparam logic [9:0] OP_XOR  = 10'h020;
    localparam logic [9:0] OP_SRL  = 10'h040;
    localparam logic [9:0] OP_SRA  = 10'h080;
    localparam logic [9:0] OP_OR   = 10'h100;
    localparam logic [9:0] OP_AND  = 10'h200;

    typedef struct {
        logic [31:0] instr;
        logic [9:0]  op;
        logic [1:0]  s1;    // 3 = operand selects not checked
        logic        s2;
        logic [31:0] imm;
        logic [31:0] mask;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        rd_wr;
        logic        ill;
        logic [31:0] pc;
    } vec_t;

    logic        clk;
    logic        rst_b;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_alu_opcode;
    logic [1:0]  out_src1_sel;
    logic        out_src2_sel;
    logic [31:0] out_imm;
    logic [31:0] out_pc;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic        out_rd_wr;
    logic        out_illegal;

    int pass_cnt  = 0;
    int total_cnt = 0;
    vec_t vecs[$];
    vec_t exp_q[$];

    alu_decode dut (
        .clk            (clk),
        .rst_b          (rst_b),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_pc          (in_pc),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_alu_opcode (out_alu_opcode),
        .out_src1_sel   (out_src1_sel),
        .out_src2_sel   (out_src2_sel),
        .out_imm        (out_imm),
        .out_pc         (out_pc),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_rd         (out_rd),
        .out_rd_wr      (out_rd_wr),
        .out_illegal    (out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic addv(input logic [31:0] instr, input logic [9:0] op, input logic [1:0] s1,
                        input logic s2, input logic [31:0] imm, input logic [31:0] mask,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic rd_wr, input logic ill);
        vec_t v;
        v.instr = instr; v.op = op; v.s1 = s1; v.s2 = s2; v.imm = imm; v.mask = mask;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.rd_wr = rd_wr; v.ill = ill; v.pc = 32'd0;
        vecs.push_back(v);
    endtask

    // Present one instruction and wait (bounded) for the handshake; leaves in_valid high
    task automatic send(input int idx, input logic [31:0] pc);
        vec_t v;
        bit ok;
        v = vecs[idx];
        v.pc = pc;
        in_valid = 1'b1;
        in_instr = v.instr;
        in_pc    = pc;
        ok = 1'b0;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (in_ready && !flush) begin
                exp_q.push_back(v);
                ok = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk($sformatf("accept_%08h", v.instr), {31'd0, ok}, 32'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
        chk("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake on the output side is checked against the queue head
    always @(negedge clk) begin
        vec_t e;
        if (rst_b && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk($sformatf("%08h.opcode", e.instr), {22'd0, out_alu_opcode}, {22'd0, e.op});
                if (e.s1 != 2'd3) begin
                    chk($sformatf("%08h.src1", e.instr), {30'd0, out_src1_sel}, {30'd0, e.s1});
                    chk($sformatf("%08h.src2", e.instr), {31'd0, out_src2_sel}, {31'd0, e.s2});
                end
                if (e.mask != 32'd0)
                    chk($sformatf("%08h.imm", e.instr), out_imm & e.mask, e.imm);
                chk($sformatf("%08h.pc", e.instr), out_pc, e.pc);
                chk($sformatf("%08h.rs1", e.instr), {27'd0, out_rs1}, {27'd0, e.rs1});
                chk($sformatf("%08h.rs2", e.instr), {27'd0, out_rs2}, {27'd0, e.rs2});
                chk($sformatf("%08h.rd", e.instr), {27'd0, out_rd}, {27'd0, e.rd});
                chk($sformatf("%08h.rd_wr", e.instr), {31'd0, out_rd_wr}, {31'd0, e.rd_wr});
                chk($sformatf("%08h.illegal", e.instr), {31'd0, out_illegal}, {31'd0, e.ill});
            end
        end
    end

    initial begin
        int n_main;
        //   instr         op       s1    s2    imm           mask          rs1    rs2    rd     wr    ill
        addv(32'h002081B3, OP_ADD,  2'd0, 1'b0, 32'h0,        32'h0,        5'd1,  5'd2,  5'd3,  1'b1, 1'b0);
        addv(32'h407302B3, OP_SUB,  2'd0, 1'b0, 32'h0,        32'h0,        5'd6,  5'd7,  5'd5,  1'b1, 1'b0);
        addv(32'h003110B3, OP_SLL,  2'd0, 1'b0, 32'h0,        32'h0,        5'd2,  5'd3,  5'd1,  1'b1, 1'b0);
        addv(32'h0062A233, OP_SLT,  2'd0, 1'b0, 32'h0,        32'h0,        5'd5,  5'd6,  5'd4,  1'b1, 1'b0);
        addv(32'h0062B233, OP_SLTU, 2'd0, 1'b0, 32'h0,        32'h0,        5'd5,  5'd6,  5'd4,  1'b1, 1'b0);
        addv(32'h0062C233, OP_XOR,  2'd0, 1'b0, 32'h0,        32'h0,        5'd5,  5'd6,  5'd4,  1'b1, 1'b0);
        addv(32'h0062D233, OP_SRL,  2'd0, 1'b0, 32'h0,        32'h0,        5'd5,  5'd6,  5'd4,  1'b1, 1'b0);
        addv(32'h4062D233, OP_SRA,  2'd0, 1'b0, 32'h0,        32'h0,        5'd5,  5'd6,  5'd4,  1'b1, 1'b0);
        addv(32'h0062E233, OP_OR,   2'd0, 1'b0, 32'h0,        32'h0,        5'd5,  5'd6,  5'd4,  1'b1, 1'b0);
        addv(32'h0062F233, OP_AND,  2'd0, 1'b0, 32'h0,        32'h0,        5'd5,  5'd6,  5'd4,  1'b1, 1'b0);
        addv(32'h40335293, OP_SRA,  2'd0, 1'b1, 32'h3,        32'h1F,       5'd6,  5'd3,  5'd5,  1'b1, 1'b0);
        addv(32'h01F15093, OP_SRL,  2'd0, 1'b1, 32'h1F,       32'h1F,       5'd2,  5'd31, 5'd1,  1'b1, 1'b0);
        addv(32'hFFF00093, OP_ADD,  2'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  5'd31, 5'd1,  1'b1, 1'b0);
        addv(32'h40010093, OP_ADD,  2'd0, 1'b1, 32'h00000400, 32'hFFFFFFFF, 5'd2,  5'd0,  5'd1,  1'b1, 1'b0);
        addv(32'h80044393, OP_XOR,  2'd0, 1'b1, 32'hFFFFF800, 32'hFFFFFFFF, 5'd8,  5'd0,  5'd7,  1'b1, 1'b0);
        addv(32'h123450B7, OP_ADD,  2'd2, 1'b1, 32'h12345000, 32'hFFFFFFFF, 5'd8,  5'd3,  5'd1,  1'b1, 1'b0);
        addv(32'hFFFFF197, OP_ADD,  2'd1, 1'b1, 32'hFFFFF000, 32'hFFFFFFFF, 5'd31, 5'd31, 5'd3,  1'b1, 1'b0);
        addv(32'h0020E463, OP_SLTU, 2'd0, 1'b0, 32'h00000008, 32'hFFFFFFFF, 5'd1,  5'd2,  5'd8,  1'b0, 1'b0);
        addv(32'hFE208EE3, OP_SUB,  2'd0, 1'b0, 32'hFFFFFFFC, 32'hFFFFFFFF, 5'd1,  5'd2,  5'd29, 1'b0, 1'b0);
        addv(32'h0041C863, OP_SLT,  2'd0, 1'b0, 32'h00000010, 32'hFFFFFFFF, 5'd3,  5'd4,  5'd16, 1'b0, 1'b0);
        addv(32'h0020A623, OP_ADD,  2'd0, 1'b1, 32'h0000000C, 32'hFFFFFFFF, 5'd1,  5'd2,  5'd12, 1'b0, 1'b0);
        addv(32'hFF80A283, OP_ADD,  2'd0, 1'b1, 32'hFFFFFFF8, 32'hFFFFFFFF, 5'd1,  5'd24, 5'd5,  1'b1, 1'b0);
        addv(32'h001000EF, OP_ADD,  2'd1, 1'b1, 32'h00000800, 32'hFFFFFFFF, 5'd0,  5'd1,  5'd1,  1'b1, 1'b0);
        addv(32'hFFFFF06F, OP_ADD,  2'd1, 1'b1, 32'hFFFFFFFE, 32'hFFFFFFFF, 5'd31, 5'd31, 5'd0,  1'b0, 1'b0);
        addv(32'h004100E7, OP_ADD,  2'd0, 1'b1, 32'h00000004, 32'hFFFFFFFF, 5'd2,  5'd4,  5'd1,  1'b1, 1'b0);
        addv(32'h00208033, OP_ADD,  2'd0, 1'b0, 32'h0,        32'h0,        5'd1,  5'd2,  5'd0,  1'b0, 1'b0);
`ifdef DECODE_ILLEGAL_CHECK_EN
        addv(32'h00000FFF, OP_NONE, 2'd3, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd31, 1'b0, 1'b1);
        addv(32'h020000B3, OP_NONE, 2'd3, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd1,  1'b0, 1'b1);
        addv(32'h00002063, OP_NONE, 2'd3, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  1'b0, 1'b1);
        addv(32'h400010B3, OP_NONE, 2'd3, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd1,  1'b0, 1'b1);
`else
        addv(32'h00000FFF, OP_ADD,  2'd3, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd31, 1'b0, 1'b0);
        addv(32'h020000B3, OP_ADD,  2'd0, 1'b0, 32'h0,        32'h0,        5'd0,  5'd0,  5'd1,  1'b1, 1'b0);
`endif
        n_main = vecs.size();

        rst_b = 1'b0; in_valid = 1'b0; in_instr = 32'd0; in_pc = 32'd0;
        flush = 1'b0; out_ready = 1'b1;
        #12;
        chk("rst.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst.opcode", {22'd0, out_alu_opcode}, 32'd0);
        chk("rst.imm", out_imm, 32'd0);
        chk("rst.pc", out_pc, 32'd0);
        chk("rst.rd_wr", {31'd0, out_rd_wr}, 32'd0);
        chk("rst.sel", {29'd0, out_src1_sel, out_src2_sel}, 32'd0);
        chk("rst.regs", {17'd0, out_rs1, out_rs2, out_rd}, 32'd0);
        chk("rst.illegal", {31'd0, out_illegal}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_b = 1'b1;

        // Back-to-back stream of every vector
        for (int i = 0; i < n_main; i++) send(i, 32'h0000_1000 + 32'(i) * 32'd4);
        in_valid = 1'b0;
        drain();

        // Stall: entry held stable and in_ready low for three cycles
        send(0, 32'h0000_2000);
        out_ready = 1'b0;
        fork
            send(1, 32'h0000_2004);
            begin
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    chk("stall.out_valid", {31'd0, out_valid}, 32'd1);
                    chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall.opcode", {22'd0, out_alu_opcode}, {22'd0, OP_ADD});
                    chk("stall.pc", out_pc, 32'h0000_2000);
                    chk("stall.rd", {27'd0, out_rd}, 32'd3);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();

        // Flush coinciding with an accept: nothing enters the register
        in_valid = 1'b1; in_instr = 32'h123450B7; in_pc = 32'h0000_3000; flush = 1'b1;
        @(negedge clk);
        chk("flush_acc.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_acc.out_valid", {31'd0, out_valid}, 32'd0);

        // Flush of a stalled valid entry
        @(posedge clk);
        #1;
        send(15, 32'h0000_3100);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b1;
        @(negedge clk);
        chk("flush_stall.pre", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        chk("flush_stall.out_valid", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;

        // Asynchronous reset while an entry is stalled
        send(15, 32'h0000_3200);
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        chk("rst_stall.pre", {31'd0, out_valid}, 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        chk("rst_stall.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall.opcode", {22'd0, out_alu_opcode}, 32'd0);
        chk("rst_stall.imm", out_imm, 32'd0);
        chk("rst_stall.pc", out_pc, 32'd0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        rst_b = 1'b1; out_ready = 1'b1;

        // Normal operation resumes after reset
        send(10, 32'h0000_4000);
        in_valid = 1'b0;
        drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
